// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Bridges the 32-bit MEM stage to a 16-bit external SRAM. Each 32-bit load
// or store is split into two half-word SRAM accesses, low half then high
// half, each held on the pins for ACCESS_CYCLES cycles.
//
// Handshake: the MEM stage presents wr_en/rd_en with address/write_data.
// ready is combinational: it is 1 while idle with no request and for the
// single DONE cycle that completes a transaction, and 0 otherwise. A new
// request therefore pulls ready low in the same cycle it appears, and the
// pipeline may advance only in a cycle where ready is 1. Request inputs are
// sampled only in IDLE; a request still asserted in DONE is not restarted
// and is picked up again in IDLE on the following cycle.
module sram_mem_controller #(
  parameter int unsigned BASE_ADDR     = 1024,
  parameter int unsigned ACCESS_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_WE_N,
  output logic [1:0]  o_dbg_state
);

  localparam int unsigned CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_is_write;
  logic [16:0]       r_word;
  logic [31:0]       r_wdata;
  logic [31:0]       r_read_data;
  logic [17:0]       r_sram_addr;

  logic              w_req;
  logic              w_last;
  logic [31:0]       w_offset;
  logic [16:0]       w_word;
  logic              w_unused;
  logic              w_ready;
  logic              w_we_n;
  logic              w_dq_oe;
  logic [15:0]       w_dq_out;

  // Request decode and word index; the subtract wraps, only 17 word bits kept
  assign w_req    = wr_en | rd_en;
  assign w_last   = (r_cnt == CNT_LAST);
  assign w_offset = address - 32'(BASE_ADDR);
  assign w_word   = w_offset[18:2];
  assign w_unused = &{1'b0, w_offset[1:0], w_offset[31:19]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: each half stays for ACCESS_CYCLES cycles
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_req)  w_next_state = S_LOW;
      S_LOW:   if (w_last) w_next_state = S_HIGH;
      S_HIGH:  if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode: stall signal, write strobe and data bus drive
  always_comb begin
    w_ready  = 1'b0;
    w_we_n   = 1'b1;
    w_dq_oe  = 1'b0;
    w_dq_out = 16'h0000;
    case (r_state)
      S_IDLE: begin
        w_ready = ~w_req;
      end
      S_LOW: begin
        w_we_n   = ~r_is_write;
        w_dq_oe  = r_is_write;
        w_dq_out = r_wdata[15:0];
      end
      S_HIGH: begin
        w_we_n   = ~r_is_write;
        w_dq_oe  = r_is_write;
        w_dq_out = r_wdata[31:16];
      end
      S_DONE: begin
        w_ready = 1'b1;
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  // Transaction latch, phase counter and SRAM address register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_is_write  <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_sram_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_is_write  <= wr_en;
            r_word      <= w_word;
            r_wdata     <= write_data;
            r_sram_addr <= {w_word, 1'b0};
          end
        end
        S_LOW: begin
          if (w_last) begin
            r_cnt       <= '0;
            r_sram_addr <= {r_word, 1'b1};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_HIGH: begin
          if (w_last) begin
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  // Load capture: each half is sampled on the last cycle of its phase
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_read_data <= '0;
    end else if (!r_is_write && w_last) begin
      if (r_state == S_LOW) begin
        r_read_data[15:0] <= SRAM_DQ;
      end else if (r_state == S_HIGH) begin
        r_read_data[31:16] <= SRAM_DQ;
      end
    end
  end

  assign SRAM_DQ     = w_dq_oe ? w_dq_out : 16'bz;
  assign SRAM_WE_N   = w_we_n;
  assign SRAM_ADDR   = r_sram_addr;
  assign ready       = w_ready;
  assign read_data   = r_read_data;
  assign o_dbg_state = r_state;

endmodule
